tank_word_reader: RTL and testbench
===================================

// Module: tank_word_reader
// PURPOSE
//  Serial-to-parallel read port sitting directly downstream of a recirculating delay-line tank.
//  Tracks digit/word position of the serial stream, captures one addressed word on request,
//  and presents it in parallel to the order/arithmetic logic via a valid/ready handshake.
//  Observes the tank only (never alters recirculation). Serial order is LSB first.
// PARAMETERS
//  WORD_WIDTH  18  digits per minor cycle (17 data + 1 gap digit), incl. gap
//  STORE_LEN   32  words per tank revolution
//  ADDR_W      5   address width; must satisfy 2**ADDR_W >= STORE_LEN
// PORTS
//  clk        in   1           system clock, one digit per cycle
//  rst        in   1           asynchronous, active-high reset
//  bit_in     in   1           serial tank stream (delay line monitor tap)
//  tank_sync  in   1           pulse coincident with digit 0 of word 0 on bit_in
//  rd_valid   in   1           read request valid
//  rd_addr    in   ADDR_W      word address to read
//  rd_ready   out  1           request accepted when rd_valid && rd_ready
//  out_valid  out  1           captured word available
//  out_ready  in   1           consumer accepts word when out_valid && out_ready
//  out_word   out  WORD_WIDTH  captured word, bit 0 = first digit received
//  synced     out  1           position counters aligned to tank_sync
//  sync_err   out  1           one-cycle pulse: tank_sync arrived off-position
//  addr_err   out  1           one-cycle pulse: accepted rd_addr >= STORE_LEN
// BEHAVIOUR
//  Reset (async): all outputs 0 except rd_ready=0 until next clk; counters 0; FSM IDLE; synced=0.
//  Position: digit_cnt 0..WORD_WIDTH-1, word_cnt 0..STORE_LEN-1; digit wraps -> word++;
//   word wraps STORE_LEN-1 -> 0. tank_sync forces (0,0) in that cycle and sets synced.
//  sync_err: tank_sync seen while synced and counters != (0,0); counters realign;
//   any capture in progress aborts to WAIT (retries the same address next revolution).
//  FSM: IDLE -> (accept) WAIT -> SHIFT -> HOLD -> IDLE.
//   IDLE: rd_ready=1. On accept latch rd_addr. If rd_addr >= STORE_LEN: pulse addr_err,
//    stay IDLE, no output.
//   WAIT: rd_ready=0. Move to SHIFT when synced && word_cnt==addr && digit_cnt==0;
//    bit_in of that cycle is digit 0. Partial words are never captured: a request accepted
//    mid-word of its own address waits a full revolution.
//   SHIFT: shift in bit_in for WORD_WIDTH cycles total (incl. entry cycle); digit k -> bit k.
//   HOLD: out_valid=1, out_word stable; on out_ready -> IDLE; rd_ready=1 next cycle.
//  Latency: out_valid rises the cycle after digit WORD_WIDTH-1 of the addressed word;
//   worst case from accept = STORE_LEN*WORD_WIDTH + WORD_WIDTH cycles.
//  Accept in IDLE while addressed word begins that same cycle: entry to SHIFT is next word
//   boundary only (accept cycle never samples data); i.e. waits one revolution.
//  Unsynced: request accepted, held in WAIT until synced.
//  out_word holds last captured value after handshake until next capture completes.
// STRUCTURE
//  Shared include edsac_mem_defs.vh: WORD_WIDTH/STORE_LEN defaults, FSM state encodings.
//  Sub-module tank_position_counter: digit/word counters, sync realign, synced, sync_err.
//  Top: FSM, address latch, shift register, handshake.
// TESTING (WORD_WIDTH=18, STORE_LEN=32, revolution 576 cycles)
//  1. Reset mid-SHIFT -> all outputs 0 immediately; synced=0; no out_valid until re-synced.
//  2. Tank holds word 5=18'h2A5A5; sync, request addr 5 during word 0 -> out_word=18'h2A5A5,
//     out_valid the cycle after (5,17).
//  3. Request addr 7 accepted at (7,3) -> capture on next revolution; latency 576-3+18 cycles.
//  4. Request addr 31 (last word) then addr 0 back-to-back -> wrap correct, both words exact.
//  5. tank_sync injected at (12,4) during SHIFT -> sync_err pulse 1 cycle, capture restarts,
//     correct word delivered; out_ready held 0 for 10 cycles -> out_word stable, rd_ready=0.
//  6. STORE_LEN=24, ADDR_W=5: request addr 30 -> addr_err pulse, FSM stays IDLE, out_valid=0.

Source files
------------

// File: rtl/tank_word_reader_pkg.sv
// Shared definitions for the tank word reader.
// Contents:
//   DEF_WORD_WIDTH / DEF_STORE_LEN / DEF_ADDR_W : default tank geometry
//   rd_state_t and ST_* : read FSM state encodings
//   addr_in_range()      : word address bounds check against the store length
package tank_word_reader_pkg;

    localparam int unsigned DEF_WORD_WIDTH = 18;  // 17 data digits + 1 gap digit
    localparam int unsigned DEF_STORE_LEN  = 32;  // words per tank revolution
    localparam int unsigned DEF_ADDR_W     = 5;

    typedef logic [1:0] rd_state_t;

    localparam rd_state_t ST_IDLE  = 2'd0;
    localparam rd_state_t ST_WAIT  = 2'd1;
    localparam rd_state_t ST_SHIFT = 2'd2;
    localparam rd_state_t ST_HOLD  = 2'd3;

    function automatic logic addr_in_range(input int unsigned addr,
                                           input int unsigned store_len);
        return addr < store_len;
    endfunction

endpackage

// File: rtl/tank_position_counter.sv
// Digit/word position tracker for a recirculating tank stream.
// Ports:
//   clk, rst      : clock (one digit per cycle), async active-high reset
//   tank_sync     : pulse coincident with digit 0 of word 0
//   digit_cnt     : digit position of the current cycle (0 when tank_sync is high)
//   word_cnt      : word position of the current cycle (0 when tank_sync is high)
//   pos_valid     : position is trustworthy this cycle (synced, or sync arriving now)
//   synced        : registered; counters have been aligned to tank_sync
//   sync_err_now  : combinational; tank_sync arrived while synced but off-position
//   sync_err      : registered one-cycle pulse of sync_err_now
module tank_position_counter
    import tank_word_reader_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int unsigned STORE_LEN  = DEF_STORE_LEN,
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DIGIT_W    = $clog2(WORD_WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tank_sync,
    output logic [DIGIT_W-1:0] digit_cnt,
    output logic [ADDR_W-1:0]  word_cnt,
    output logic               pos_valid,
    output logic               synced,
    output logic               sync_err_now,
    output logic               sync_err
);

    logic [DIGIT_W-1:0] digit_q, digit_d;
    logic [ADDR_W-1:0]  word_q,  word_d;
    logic               synced_q, synced_d;
    logic               sync_err_q, sync_err_d;

    always_comb begin
        // tank_sync overrides the running count in the very cycle it arrives.
        digit_cnt    = tank_sync ? '0 : digit_q;
        word_cnt     = tank_sync ? '0 : word_q;
        pos_valid    = synced_q | tank_sync;
        sync_err_now = tank_sync && synced_q && ((digit_q != '0) || (word_q != '0));

        if (digit_cnt == DIGIT_W'(WORD_WIDTH - 1)) begin
            digit_d = '0;
            word_d  = (word_cnt == ADDR_W'(STORE_LEN - 1)) ? '0 : word_cnt + ADDR_W'(1);
        end else begin
            digit_d = digit_cnt + DIGIT_W'(1);
            word_d  = word_cnt;
        end

        synced_d   = synced_q | tank_sync;
        sync_err_d = sync_err_now;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_q    <= '0;
            word_q     <= '0;
            synced_q   <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            digit_q    <= digit_d;
            word_q     <= word_d;
            synced_q   <= synced_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign synced   = synced_q;
    assign sync_err = sync_err_q;

endmodule

// File: rtl/tank_word_reader.sv
// Serial-to-parallel read port on a recirculating delay-line tank (observe only).
// Captures one addressed word per request, LSB (digit 0) first, and hands it over
// through a valid/ready pair.
// Ports:
//   clk, rst            : clock (one digit per cycle), async active-high reset
//   bit_in, tank_sync   : tank monitor tap and word-0/digit-0 marker
//   rd_valid, rd_addr   : read request; accepted when rd_valid && rd_ready
//   rd_ready            : high in IDLE (low until the first clock after reset)
//   out_valid, out_word : captured word, held until out_ready
//   out_ready           : consumer accept
//   synced, sync_err    : position alignment status / off-position sync pulse
//   addr_err            : pulse after accepting an address beyond the store
// WORD_WIDTH must be at least 2.
module tank_word_reader
    import tank_word_reader_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int unsigned STORE_LEN  = DEF_STORE_LEN,
    parameter int unsigned ADDR_W     = DEF_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bit_in,
    input  logic                  tank_sync,
    input  logic                  rd_valid,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic                  rd_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] out_word,
    output logic                  synced,
    output logic                  sync_err,
    output logic                  addr_err
);

    localparam int unsigned DIGIT_W = $clog2(WORD_WIDTH);

    logic [DIGIT_W-1:0] digit_cnt;
    logic [ADDR_W-1:0]  word_cnt;
    logic               pos_valid;
    logic               sync_err_now;

    tank_position_counter #(
        .WORD_WIDTH (WORD_WIDTH),
        .STORE_LEN  (STORE_LEN),
        .ADDR_W     (ADDR_W),
        .DIGIT_W    (DIGIT_W)
    ) u_pos (
        .clk          (clk),
        .rst          (rst),
        .tank_sync    (tank_sync),
        .digit_cnt    (digit_cnt),
        .word_cnt     (word_cnt),
        .pos_valid    (pos_valid),
        .synced       (synced),
        .sync_err_now (sync_err_now),
        .sync_err     (sync_err)
    );

    rd_state_t           state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WORD_WIDTH-1:0] shift_q, shift_d;
    logic [WORD_WIDTH-1:0] out_word_q, out_word_d;
    logic [DIGIT_W-1:0]  cnt_q, cnt_d;
    logic                addr_err_q, addr_err_d;
    logic                rdy_en_q;  // keeps rd_ready low until the first clock after reset

    logic                  accept;
    logic                  start_hit;
    logic [WORD_WIDTH-1:0] shifted;

    assign rd_ready  = rdy_en_q && (state_q == ST_IDLE);
    assign accept    = rd_valid && rd_ready;
    assign start_hit = pos_valid && (word_cnt == addr_q) && (digit_cnt == '0);
    // Digits arrive LSB first: insert at the top so digit k ends at bit k.
    assign shifted   = {bit_in, shift_q[WORD_WIDTH-1:1]};

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        shift_d    = shift_q;
        out_word_d = out_word_q;
        cnt_d      = cnt_q;
        addr_err_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d = rd_addr;
                    if (addr_in_range(32'(rd_addr), STORE_LEN)) begin
                        state_d = ST_WAIT;
                    end else begin
                        addr_err_d = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                // The matching cycle carries digit 0 and counts as the first shift.
                if (start_hit) begin
                    shift_d = shifted;
                    cnt_d   = DIGIT_W'(1);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (sync_err_now) begin
                    // Realigned mid-capture: the bits so far are suspect, so restart.
                    if (start_hit) begin
                        shift_d = shifted;
                        cnt_d   = DIGIT_W'(1);
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    shift_d = shifted;
                    if (cnt_q == DIGIT_W'(WORD_WIDTH - 1)) begin
                        out_word_d = shifted;
                        cnt_d      = '0;
                        state_d    = ST_HOLD;
                    end else begin
                        cnt_d = cnt_q + DIGIT_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            shift_q    <= '0;
            out_word_q <= '0;
            cnt_q      <= '0;
            addr_err_q <= 1'b0;
            rdy_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            shift_q    <= shift_d;
            out_word_q <= out_word_d;
            cnt_q      <= cnt_d;
            addr_err_q <= addr_err_d;
            rdy_en_q   <= 1'b1;
        end
    end

    assign out_valid = (state_q == ST_HOLD);
    assign out_word  = out_word_q;
    assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_tank_word_reader.sv
// Directed bench for tank_word_reader: a bench-owned tank model drives the serial
// stream; expectations are hand-chosen word constants and hand-computed positions.
module tb_tank_word_reader;

    localparam int unsigned WW  = 18;
    localparam int unsigned SL  = 32;
    localparam int unsigned AW  = 5;
    localparam int          REV = WW * SL;  // 576

    localparam logic [WW-1:0] W0  = 18'h00001;
    localparam logic [WW-1:0] W5  = 18'h2A5A5;
    localparam logic [WW-1:0] W7  = 18'h20000;
    localparam logic [WW-1:0] W12 = 18'h1E0F3;
    localparam logic [WW-1:0] W31 = 18'h3FFFE;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          bit_in;
    logic          tank_sync;
    logic          rd_valid = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_ready;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [WW-1:0] out_word;
    logic          synced;
    logic          sync_err;
    logic          addr_err;

    logic          rd_valid24 = 1'b0;
    logic [AW-1:0] rd_addr24 = '0;
    logic          tank_sync24 = 1'b0;
    logic          out_ready24 = 1'b0;
    logic          rd_ready24;
    logic          out_valid24;
    logic [WW-1:0] out_word24;
    logic          synced24;
    logic          sync_err24;
    logic          addr_err24;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Tank model: free-running position, optional jump back to (0,0).
    logic [WW-1:0] mem [SL];
    int            tb_pos = 0;
    logic          jump_req = 1'b0;
    logic          sync_en = 1'b0;
    int            eff_pos;
    logic [4:0]    cur_word;
    logic [4:0]    cur_digit;

    assign eff_pos   = jump_req ? 0 : tb_pos;
    assign cur_word  = 5'(eff_pos / WW);
    assign cur_digit = 5'(eff_pos % WW);
    assign bit_in    = mem[cur_word][cur_digit];
    assign tank_sync = sync_en && (eff_pos == 0);

    always @(posedge clk) tb_pos <= (eff_pos == REV - 1) ? 0 : eff_pos + 1;

    tank_word_reader #(
        .WORD_WIDTH (WW),
        .STORE_LEN  (SL),
        .ADDR_W     (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bit_in    (bit_in),
        .tank_sync (tank_sync),
        .rd_valid  (rd_valid),
        .rd_addr   (rd_addr),
        .rd_ready  (rd_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .synced    (synced),
        .sync_err  (sync_err),
        .addr_err  (addr_err)
    );

    tank_word_reader #(
        .WORD_WIDTH (WW),
        .STORE_LEN  (24),
        .ADDR_W     (AW)
    ) dut24 (
        .clk       (clk),
        .rst       (rst),
        .bit_in    (bit_in),
        .tank_sync (tank_sync24),
        .rd_valid  (rd_valid24),
        .rd_addr   (rd_addr24),
        .rd_ready  (rd_ready24),
        .out_valid (out_valid24),
        .out_ready (out_ready24),
        .out_word  (out_word24),
        .synced    (synced24),
        .sync_err  (sync_err24),
        .addr_err  (addr_err24)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pos(input int pos, input string tag);
        int n = 0;
        while (eff_pos != pos && n < 2 * REV) begin
            tick();
            n++;
        end
        check(tag, 32'(eff_pos == pos), 32'd1);
    endtask

    task automatic wait_valid(input int limit, input string tag);
        int n = 0;
        while (!out_valid && n < limit) begin
            tick();
            n++;
        end
        check(tag, 32'(out_valid), 32'd1);
    endtask

    task automatic request(input logic [AW-1:0] a, input string tag);
        rd_valid = 1'b1;
        rd_addr  = a;
        check(tag, 32'(rd_ready), 32'd1);
        tick();
        rd_valid = 1'b0;
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check(tag, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        logic seen;
        for (int i = 0; i < int'(SL); i++) mem[i] = 18'((i * 32'h1F3D7) ^ 32'h2C3A9);
        mem[0]  = W0;
        mem[5]  = W5;
        mem[7]  = W7;
        mem[12] = W12;
        mem[31] = W31;

        // Reset values.
        #12;
        check("rst_rd_ready", 32'(rd_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_synced", 32'(synced), 32'd0);
        check("rst_out_word", 32'(out_word), 32'd0);
        check("rst_sync_err", 32'(sync_err), 32'd0);
        check("rst_addr_err", 32'(addr_err), 32'd0);
        tick();
        rst = 1'b0;
        check("rd_ready_before_clk", 32'(rd_ready), 32'd0);
        tick();
        check("rd_ready_after_clk", 32'(rd_ready), 32'd1);

        // Word 5 requested during word 0.
        sync_en = 1'b1;
        wait_pos(0, "wait_first_sync");
        tick();
        check("synced_after_sync", 32'(synced), 32'd1);
        request(5'd5, "req5_ready");
        wait_pos(5 * WW + 17, "wait_w5_last_digit");
        check("w5_not_early", 32'(out_valid), 32'd0);
        tick();
        check("w5_valid", 32'(out_valid), 32'd1);
        check("w5_word", 32'(out_word), 32'(W5));
        handshake("w5_handshake");
        check("w5_rd_ready_after", 32'(rd_ready), 32'd1);

        // Async reset in the middle of a capture.
        request(5'd5, "req5b_ready");
        wait_pos(5 * WW + 6, "wait_mid_shift");
        #2;
        rst     = 1'b1;
        sync_en = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_rd_ready", 32'(rd_ready), 32'd0);
        check("midrst_synced", 32'(synced), 32'd0);
        check("midrst_out_word", 32'(out_word), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        request(5'd5, "req5_unsynced");
        seen = 1'b0;
        for (int i = 0; i < REV + 100; i++) begin
            seen = seen | out_valid;
            tick();
        end
        check("unsynced_no_valid", 32'(seen), 32'd0);
        check("unsynced_synced", 32'(synced), 32'd0);
        sync_en = 1'b1;
        wait_valid(3 * REV, "resync_valid");
        check("resync_word", 32'(out_word), 32'(W5));
        handshake("resync_handshake");

        // Accept at (7,3): a full revolution minus 3 digits plus the word itself.
        wait_pos(7 * WW + 3, "wait_7_3");
        request(5'd7, "req7_ready");
        n = 1;
        while (!out_valid && n < 2000) begin
            tick();
            n++;
        end
        check("w7_latency", 32'(n), 32'(REV - 3 + WW));
        check("w7_word", 32'(out_word), 32'(W7));
        handshake("w7_handshake");

        // Last word then word 0, back to back.
        request(5'd31, "req31_ready");
        check("req31_no_addr_err", 32'(addr_err), 32'd0);
        wait_valid(2 * REV, "w31_valid");
        check("w31_wrap_pos", 32'(eff_pos), 32'd0);
        check("w31_word", 32'(out_word), 32'(W31));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        request(5'd0, "req0_ready");
        wait_valid(2 * REV, "w0_valid");
        check("w0_pos", 32'(eff_pos), 32'(WW));
        check("w0_word", 32'(out_word), 32'(W0));
        handshake("w0_handshake");

        // Off-position sync during capture of word 12.
        wait_pos(10 * WW, "wait_w10");
        request(5'd12, "req12_ready");
        wait_pos(12 * WW + 4, "wait_12_4");
        jump_req = 1'b1;
        tick();
        jump_req = 1'b0;
        check("sync_err_pulse", 32'(sync_err), 32'd1);
        check("sync_err_synced", 32'(synced), 32'd1);
        tick();
        check("sync_err_cleared", 32'(sync_err), 32'd0);
        check("w12_not_early", 32'(out_valid), 32'd0);
        wait_valid(2 * REV, "w12_valid");
        check("w12_pos", 32'(eff_pos), 32'(13 * WW));
        check("w12_word", 32'(out_word), 32'(W12));
        for (int i = 0; i < 10; i++) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_word", 32'(out_word), 32'(W12));
            check("hold_rd_ready", 32'(rd_ready), 32'd0);
            tick();
        end
        handshake("w12_handshake");

        // Out-of-range address on a 24-word store.
        check("s24_rd_ready", 32'(rd_ready24), 32'd1);
        rd_valid24 = 1'b1;
        rd_addr24  = 5'd30;
        tick();
        rd_valid24 = 1'b0;
        check("s24_addr_err", 32'(addr_err24), 32'd1);
        check("s24_out_valid", 32'(out_valid24), 32'd0);
        check("s24_stays_idle", 32'(rd_ready24), 32'd1);
        tick();
        check("s24_addr_err_pulse", 32'(addr_err24), 32'd0);
        check("s24_out_valid_later", 32'(out_valid24), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
